regfile_seq: RTL

- 32-entry general-purpose register file built from the team's single-cycle write-enabled storage elements.
- Sits directly downstream of the individual register stage: it owns the write-address decode that drives each entry's write enable, and the read muxing that consumes each entry's q.
- Entry 0 is hardwired zero.
- Adds a multi-cycle clear sequencer so software can zero the file without a reset.

---
 rtl/regfile_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_seq.sv
// 32-entry register file with hardwired-zero entry 0 and a multi-cycle clear sequencer.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    read_addr1,
    input  logic [AW-1:0]    read_addr2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             reg_write,
    input  logic             clear_req,
    output logic             busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic              wr_en, clr_en;
    logic [WIDTH-1:0]  mem [1:DEPTH-1];
    logic [WIDTH-1:0]  stored1, stored2;

    // State and clear-index register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= AW'(1);
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state and per-cycle enables; writes are only accepted while IDLE
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                wr_en = reg_write && (write_addr != '0);
                if (clear_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (idx == AW'(DEPTH - 1)) state_nxt = IDLE;
                else                       idx_nxt   = idx + AW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry storage; entry 0 has no storage at all
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (wr_en && (write_addr == AW'(i)))     mem[i] <= write_data;
                else if (clr_en && (idx == AW'(i)))      mem[i] <= '0;
            end
        end
    end

    // Read muxes: address 0 falls through to the zero default
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (read_addr1 == AW'(i)) stored1 = mem[i];
            if (read_addr2 == AW'(i)) stored2 = mem[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        read_data1 = stored1;
        read_data2 = stored2;
        if (!reset && wr_en && (read_addr1 == write_addr)) read_data1 = write_data;
        if (!reset && wr_en && (read_addr2 == write_addr)) read_data2 = write_data;
    end
`else
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif

    assign busy = (state == CLEAR);

endmodule
